intrusion_scheduler: RTL and testbench
======================================

Name: intrusion_scheduler

Overview:
- Sequences the NoC security response for 16 routers.
- Collects per-router 2-bit intrusion codes into sticky pending severities.
- Picks one router at a time: highest severity first, round-robin among equal severities.
- Issues a valid/ready quarantine request to the response engine, then holds a per-router isolate bit until software releases it.
- Sits between the router intrusion detectors and the secure-core isolation logic. Its isolate vector replaces the direct per-router secure-core outputs.

Parameters:
- N_ROUTERS, 16, number of monitored routers; widths below assume 16, id width = clog2(N_ROUTERS).
- GUARD_CYCLES, 4, minimum idle cycles after each completed handshake before the next selection; range 0..15.
- CNT_W, 16, width of the saturating event counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- intrusion  input  2*N_ROUTERS  packed codes; bits [2i+1:2i] belong to router i. 00 = none, 01 = low, 10 = medium, 11 = high.
- release  input  N_ROUTERS  one-cycle pulse per router; clears isolate[i] and pending[i].
- resp_valid  output  1  quarantine request valid.
- resp_id  output  4  router id of the request.
- resp_sev  output  2  severity of the request.
- resp_ready  input  1  response engine accepts the request.
- isolate  output  N_ROUTERS  per-router quarantine, sticky until release.
- alarm  output  1  OR of isolate.
- event_count  output  CNT_W  completed handshakes, saturating at all-ones.

Behaviour:
- Reset (rst=0, async): pending_sev all 00, isolate 0, resp_valid 0, resp_id 0, resp_sev 0, rr_ptr 0, guard counter 0, event_count 0, state IDLE. Reset mid-handshake drops the request silently.
- Capture, each edge, per router i, in priority order:
  - release[i]=1: pending_sev[i] <= 00 and isolate[i] <= 0. An intrusion on i in the same cycle is dropped.
  - isolate[i]=1: pending_sev[i] held at 00; intrusion ignored.
  - Otherwise: pending_sev[i] <= max(pending_sev[i], intrusion[i]). Severity never decreases while pending.
- Selection (combinational, sub-module):
  - Candidates are routers with pending_sev != 00.
  - Choose the maximum severity; among routers at that severity, take the first at index >= rr_ptr, wrapping N-1 -> 0.
  - No candidate -> sel_valid = 0.
- FSM states: IDLE, ISSUE, GUARD.
  - IDLE: if sel_valid, then on the edge: resp_id <= sel_id, resp_sev <= sel_sev, pending_sev[sel_id] <= 00 (overrides capture for that router this cycle), state -> ISSUE.
  - ISSUE: resp_valid = 1; resp_id/resp_sev stable until handshake.
    - On resp_valid & resp_ready: isolate[resp_id] <= 1, rr_ptr <= resp_id+1 mod N, event_count += 1 (saturating), guard counter <= GUARD_CYCLES.
    - Then state -> GUARD, or -> IDLE if GUARD_CYCLES = 0.
    - New intrusions on resp_id during ISSUE re-arm pending. They are cleared on handshake because isolate is set.
    - release[resp_id] during ISSUE does not cancel the request.
  - GUARD: decrement each cycle; at 1 -> IDLE. resp_valid = 0. Capture continues.
- Latency:
  - Intrusion sampled at edge k -> pending at k.
  - With GUARD_CYCLES = 0 and resp_ready tied 1, back-to-back requests take 2 cycles each (ISSUE, then IDLE selection).
- resp_valid is registered from state (state == ISSUE). It never deasserts without a handshake except on reset.
- alarm is combinational OR of the registered isolate vector.
- Widths: severity compares unsigned 2-bit; rr_ptr wraps modulo N_ROUTERS; event_count stops at 2^CNT_W-1.

Decomposition:
- Package sc_pkg:
  - N_ROUTERS and ID_W constants.
  - Severity constants SEV_NONE/LOW/MED/HIGH.
  - 2-bit severity typedef.
  - FSM state enum {IDLE, ISSUE, GUARD}.
- One sub-module, sev_rr_arbiter: combinational. Inputs pending_sev[N], rr_ptr. Outputs sel_valid, sel_id, sel_sev.
- Capture, FSM, counters and isolate register stay in intrusion_scheduler.

Test Plan:
- Single event: intrusion[2*5+:2] = 01 for one cycle, resp_ready = 1 → resp_valid with id 5, sev 01; isolate = 0x0020, alarm = 1, event_count = 1.
- Severity priority: routers 3 (01) and 9 (11) in the same cycle, resp_ready = 1 → first request id 9 sev 11; second, after guard, id 3 sev 01.
- Round-robin: routers 2, 7, 12 all 10, rr_ptr = 0 → grants 2, 7, 12 in order. Then release all and re-raise 2 and 12 → grant 2 first, since rr_ptr wraps 13 → 0.
- Backpressure: router 4 = 11, resp_ready = 0 for 10 cycles → resp_valid, resp_id = 4 and resp_sev = 11 stay stable throughout. Handshake on ready; then guard lasts exactly 4 cycles before any next resp_valid.
- Escalation and release: router 6 raises 01, then 11 before selection → request sev 11. Once isolated, intrusion on 6 is ignored. release[6] with simultaneous intrusion → isolate[6] = 0, pending[6] = 00.
- Async reset mid-ISSUE: drop rst while resp_valid = 1 → immediately resp_valid = 0, isolate = 0, event_count = 0. After deassert with no intrusions, the block stays IDLE.

Source files
------------

// File: rtl/intrusion_scheduler_pkg.sv
// Shared constants and types for the NoC intrusion response scheduler.
package sc_pkg;

    localparam int N_ROUTERS = 16;
    localparam int ID_W      = $clog2(N_ROUTERS);

    typedef logic [1:0] sev_t;

    localparam sev_t SEV_NONE = 2'b00;
    localparam sev_t SEV_LOW  = 2'b01;
    localparam sev_t SEV_MED  = 2'b10;
    localparam sev_t SEV_HIGH = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GUARD = 2'd2
    } state_t;

    function automatic sev_t sev_max(input sev_t a, input sev_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/intrusion_scheduler_sev_rr_arbiter.sv
// Combinational picker: highest pending severity, round-robin from rr_ptr among ties.
module sev_rr_arbiter
    import sc_pkg::*;
(
    input  sev_t [N_ROUTERS-1:0] pending_sev,
    input  logic [ID_W-1:0]      rr_ptr,
    output logic                 sel_valid,
    output logic [ID_W-1:0]      sel_id,
    output sev_t                 sel_sev
);

    sev_t                 max_sev;
    logic [N_ROUTERS-1:0] match;
    logic [ID_W:0]        idx_wide;

    always_comb begin
        max_sev = SEV_NONE;
        for (int i = 0; i < N_ROUTERS; i++) begin
            if (pending_sev[i] > max_sev) begin
                max_sev = pending_sev[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_ROUTERS; gi++) begin : g_match
            assign match[gi] = (max_sev != SEV_NONE) && (pending_sev[gi] == max_sev);
        end
    endgenerate

    // Scan offsets from the far end down so the nearest match at or after rr_ptr wins.
    always_comb begin
        sel_id   = '0;
        idx_wide = '0;
        for (int k = N_ROUTERS - 1; k >= 0; k--) begin
            idx_wide = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx_wide >= (ID_W+1)'(N_ROUTERS)) begin
                idx_wide = idx_wide - (ID_W+1)'(N_ROUTERS);
            end
            if (match[idx_wide[ID_W-1:0]]) begin
                sel_id = idx_wide[ID_W-1:0];
            end
        end
    end

    assign sel_valid = |match;
    assign sel_sev   = max_sev;

endmodule

// File: rtl/intrusion_scheduler.sv
// Collects router intrusion codes, issues one quarantine request at a time and
// holds per-router isolate bits until software releases them.
module intrusion_scheduler
    import sc_pkg::*;
#(
    parameter int GUARD_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*N_ROUTERS-1:0] intrusion,
    input  logic [N_ROUTERS-1:0]   release_req,
    output logic                   resp_valid,
    output logic [ID_W-1:0]        resp_id,
    output sev_t                   resp_sev,
    input  logic                   resp_ready,
    output logic [N_ROUTERS-1:0]   isolate,
    output logic                   alarm,
    output logic [CNT_W-1:0]       event_count
);

    localparam int GUARD_W = 4;

    state_t               state_reg;
    sev_t [N_ROUTERS-1:0] pending_sev_reg;
    sev_t [N_ROUTERS-1:0] pending_sev_next;
    logic [N_ROUTERS-1:0] isolate_reg;
    logic [N_ROUTERS-1:0] isolate_next;
    logic [ID_W-1:0]      rr_ptr_reg;
    logic [ID_W-1:0]      resp_id_reg;
    sev_t                 resp_sev_reg;
    logic [GUARD_W-1:0]   guard_cnt_reg;
    logic [CNT_W-1:0]     event_count_reg;

    logic                 sel_valid;
    logic [ID_W-1:0]      sel_id;
    sev_t                 sel_sev;
    logic                 take;
    logic                 handshake;

    sev_rr_arbiter u_arbiter (
        .pending_sev (pending_sev_reg),
        .rr_ptr      (rr_ptr_reg),
        .sel_valid   (sel_valid),
        .sel_id      (sel_id),
        .sel_sev     (sel_sev)
    );

    assign take      = (state_reg == IDLE) && sel_valid;
    assign handshake = (state_reg == ISSUE) && resp_ready;

    // Pending is also cleared on the handshake edge so a re-armed router cannot be
    // picked again in the idle cycle that follows when there is no guard time.
    genvar gi;
    generate
        for (gi = 0; gi < N_ROUTERS; gi++) begin : g_router
            logic hit_sel;
            logic hit_resp;
            assign hit_sel  = take && (sel_id == ID_W'(gi));
            assign hit_resp = handshake && (resp_id_reg == ID_W'(gi));

            assign pending_sev_next[gi] =
                (release_req[gi] || isolate_reg[gi] || hit_sel || hit_resp) ? SEV_NONE :
                sev_max(pending_sev_reg[gi], intrusion[2*gi +: 2]);

            assign isolate_next[gi] = hit_resp || (isolate_reg[gi] && !release_req[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            pending_sev_reg <= '0;
            isolate_reg     <= '0;
            rr_ptr_reg      <= '0;
            resp_id_reg     <= '0;
            resp_sev_reg    <= SEV_NONE;
            guard_cnt_reg   <= '0;
            event_count_reg <= '0;
        end else begin
            pending_sev_reg <= pending_sev_next;
            isolate_reg     <= isolate_next;
            case (state_reg)
                IDLE: begin
                    if (sel_valid) begin
                        resp_id_reg  <= sel_id;
                        resp_sev_reg <= sel_sev;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (resp_ready) begin
                        rr_ptr_reg <= (resp_id_reg == ID_W'(N_ROUTERS - 1)) ? '0
                                                                           : resp_id_reg + 1'b1;
                        if (event_count_reg != {CNT_W{1'b1}}) begin
                            event_count_reg <= event_count_reg + 1'b1;
                        end
                        guard_cnt_reg <= GUARD_W'(GUARD_CYCLES);
                        state_reg     <= (GUARD_CYCLES == 0) ? IDLE : GUARD;
                    end
                end
                GUARD: begin
                    if (guard_cnt_reg <= GUARD_W'(1)) begin
                        guard_cnt_reg <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign resp_valid  = (state_reg == ISSUE);
    assign resp_id     = resp_id_reg;
    assign resp_sev    = resp_sev_reg;
    assign isolate     = isolate_reg;
    assign alarm       = |isolate_reg;
    assign event_count = event_count_reg;

endmodule

// File: tb/tb_intrusion_scheduler.sv
// Directed bench for intrusion_scheduler with hand-computed expectations.
module tb_intrusion_scheduler;
    import sc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] intrusion = '0;
    logic [15:0] release_req = '0;
    logic        resp_ready = 1'b1;
    logic        resp_valid;
    logic [3:0]  resp_id;
    sev_t        resp_sev;
    logic [15:0] isolate;
    logic        alarm;
    logic [15:0] event_count;

    int vectors = 0;
    int fails   = 0;

    intrusion_scheduler #(.GUARD_CYCLES(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .intrusion   (intrusion),
        .release_req (release_req),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_sev    (resp_sev),
        .resp_ready  (resp_ready),
        .isolate     (isolate),
        .alarm       (alarm),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic raise(input int r, input logic [1:0] sev);
        intrusion[2*r +: 2] = sev;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (!resp_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    endtask

    task automatic expect_req(input string tag, input int id, input int sev);
        wait_valid(tag, 12);
        check({tag, "_id"}, {28'b0, resp_id}, id);
        check({tag, "_sev"}, {30'b0, resp_sev}, sev);
        $display("req %s: id=%0d sev=%0d", tag, resp_id, resp_sev);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_valid", {31'b0, resp_valid}, 0);
        check("rst_id", {28'b0, resp_id}, 0);
        check("rst_isolate", {16'b0, isolate}, 0);
        check("rst_alarm", {31'b0, alarm}, 0);
        check("rst_count", {16'b0, event_count}, 0);
        tick();
        rst = 1'b1;
        tick();

        // Single event on router 5
        raise(5, 2'b01);
        tick();
        intrusion = '0;
        check("single_pre_valid", {31'b0, resp_valid}, 0);
        tick();
        check("single_valid", {31'b0, resp_valid}, 1);
        check("single_id", {28'b0, resp_id}, 5);
        check("single_sev", {30'b0, resp_sev}, 1);
        tick();
        check("single_isolate", {16'b0, isolate}, 32'h0020);
        check("single_alarm", {31'b0, alarm}, 1);
        check("single_count", {16'b0, event_count}, 1);
        check("single_post_valid", {31'b0, resp_valid}, 0);
        release_req = 16'h0020;
        tick();
        release_req = '0;
        check("single_released", {16'b0, isolate}, 0);
        tick(6);

        // Severity priority: 3 (low) and 9 (high) together
        raise(3, 2'b01);
        raise(9, 2'b11);
        tick();
        intrusion = '0;
        expect_req("prio_first", 9, 3);
        tick();
        expect_req("prio_second", 3, 1);
        tick();
        check("prio_isolate", {16'b0, isolate}, 32'h0208);
        check("prio_count", {16'b0, event_count}, 3);
        release_req = 16'h0208;
        tick();
        release_req = '0;

        // Async reset pulse to bring rr_ptr back to 0
        rst = 1'b0;
        #2;
        check("rst2_count", {16'b0, event_count}, 0);
        rst = 1'b1;
        tick();

        // Round-robin among three medium routers
        raise(2, 2'b10);
        raise(7, 2'b10);
        raise(12, 2'b10);
        tick();
        intrusion = '0;
        expect_req("rr_a", 2, 2);
        tick();
        expect_req("rr_b", 7, 2);
        tick();
        expect_req("rr_c", 12, 2);
        tick();
        check("rr_isolate", {16'b0, isolate}, 32'h1084);
        check("rr_count", {16'b0, event_count}, 3);
        release_req = 16'h1084;
        tick();
        release_req = '0;
        raise(2, 2'b10);
        raise(12, 2'b10);
        tick();
        intrusion = '0;
        expect_req("rr_wrap_a", 2, 2);
        tick();
        expect_req("rr_wrap_b", 12, 2);
        tick();
        check("rr_wrap_count", {16'b0, event_count}, 5);
        release_req = 16'h1004;
        tick();
        release_req = '0;
        tick(6);

        // Backpressure on router 4, then exact guard length
        resp_ready = 1'b0;
        raise(4, 2'b11);
        tick();
        intrusion = '0;
        expect_req("bp_start", 4, 3);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", {31'b0, resp_valid}, 1);
            check("bp_hold_id", {28'b0, resp_id}, 4);
            check("bp_hold_sev", {30'b0, resp_sev}, 3);
        end
        resp_ready = 1'b1;
        tick();
        check("bp_hs_valid", {31'b0, resp_valid}, 0);
        check("bp_hs_isolate", {16'b0, isolate}, 32'h0010);
        raise(8, 2'b01);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 1) intrusion = '0;
            check("guard_low", {31'b0, resp_valid}, 0);
        end
        tick();
        check("guard_end_valid", {31'b0, resp_valid}, 1);
        check("guard_end_id", {28'b0, resp_id}, 8);
        tick();
        check("guard_count", {16'b0, event_count}, 7);

        // Escalation during guard, then ignore while isolated, then release
        raise(6, 2'b01);
        tick();
        raise(6, 2'b11);
        tick();
        intrusion = '0;
        expect_req("esc", 6, 3);
        tick();
        check("esc_isolate", {16'b0, isolate}, 32'h0150);
        raise(6, 2'b11);
        tick();
        intrusion = '0;
        tick(6);
        check("esc_ignored", {31'b0, resp_valid}, 0);
        release_req = 16'h0040;
        raise(6, 2'b11);
        tick();
        release_req = '0;
        intrusion = '0;
        check("rel_isolate", {16'b0, isolate}, 32'h0110);
        tick(2);
        check("rel_no_req", {31'b0, resp_valid}, 0);
        check("rel_count", {16'b0, event_count}, 8);

        // Async reset while a request is outstanding
        resp_ready = 1'b0;
        raise(1, 2'b10);
        tick();
        intrusion = '0;
        expect_req("arst_pre", 1, 2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", {31'b0, resp_valid}, 0);
        check("arst_isolate", {16'b0, isolate}, 0);
        check("arst_alarm", {31'b0, alarm}, 0);
        check("arst_count", {16'b0, event_count}, 0);
        tick();
        rst = 1'b1;
        resp_ready = 1'b1;
        tick(5);
        check("arst_idle", {31'b0, resp_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
